unbound_16: RTL and testbench
=============================

// Module: unbound_16
// PURPOSE
//  Receive-side counterpart of the 5-bit bound/clamp stage. Takes COLS packed signed BO_BW lanes
//  (legal range [-16,15]) from the activation buffer and re-expands each lane to signed AB_BW.
//  Output feeds the accumulator/bias adder input of the next layer.
//  Valid/ready on both sides; 1-stage output register plus 1-entry skid buffer for full throughput.
// PARAMETERS
//  COLS   5   lanes per beat
//  BO_BW  8   signed input lane width
//  AB_BW  25  signed output lane width; BO_BW+SHIFT <= AB_BW, enforced by elaboration check
//  SHIFT  0   left-shift (fixed-point rescale) applied after sign extension, 0..AB_BW-BO_BW
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           asynchronous reset, active-low
//  i_valid        in   1           upstream beat valid
//  o_ready        out  1           upstream may transfer (i_valid & o_ready = accept)
//  i_bound_data   in   BO_BW*COLS  lane i at [(i+1)*BO_BW-1 -: BO_BW]
//  o_valid        out  1           output beat valid
//  i_ready        in   1           downstream ready (o_valid & i_ready = handoff)
//  o_acc_data     out  AB_BW*COLS  lane i at [(i+1)*AB_BW-1 -: AB_BW]
//  o_lane_err     out  COLS        per-lane out-of-range flag, travels with o_acc_data
//  i_err_clr      in   1           synchronous clear of o_err_sticky and error counter
//  o_err_sticky   out  1           set by any accepted out-of-range lane
//  o_err_cnt      out  16          count of accepted beats with >=1 out-of-range lane
// BEHAVIOUR
//  - Reset: o_valid=0, o_ready=1, o_acc_data=0, o_lane_err=0, o_err_sticky=0, o_err_cnt=0,
//    skid entry empty. Reset mid-transfer drops all buffered beats; no partial output.
//  - Lane transform, per lane x (signed BO_BW):
//    x < -16 -> c=-16, err=1; x > 15 -> c=15, err=1; otherwise c=x, err=0.
//    out = sign_extend(c to AB_BW) <<< SHIFT, with zero-fill of the low SHIFT bits.
//    No overflow is possible given the AB_BW constraint.
//  - Storage: out register (OUT) plus skid register (SKD). o_ready = ~SKD.valid (registered).
//  - Accept with OUT empty, or with OUT handed off this cycle -> transformed beat lands in OUT next cycle.
//    Latency is 1 cycle from accept to o_valid.
//  - Accept with OUT valid and no handoff this cycle -> beat lands in SKD; o_ready drops next cycle.
//  - Handoff with SKD valid -> SKD moves to OUT next cycle, SKD empties, o_ready rises.
//    A simultaneous upstream accept cannot occur in this case (o_ready=0).
//  - Handoff with SKD empty and no accept -> o_valid=0 next cycle; o_acc_data holds its last value.
//  - o_valid/o_acc_data/o_lane_err stay stable while o_valid & ~i_ready.
//  - Beat order is strictly preserved; no beat is dropped or duplicated.
//  - Sustained i_valid=1 and i_ready=1 -> one beat per cycle.
//  - Error accounting happens at upstream accept, not at handoff.
//    Sticky flag sets 1 cycle after the accepted errored beat.
//  - i_err_clr alone clears sticky and counter to 0.
//  - i_err_clr in the same cycle as an errored accept -> sticky=1 and cnt=1 (clear then count).
// CONFIGURATION
//  UNBOUND_ERR_CNT_EN defined: o_err_cnt is a 16-bit counter, +1 per accepted beat with any lane
//    error; saturates at 16'hFFFF (no wrap); cleared by i_err_clr.
//  Not defined: no counter logic is built; o_err_cnt is tied to 16'h0000.
//    o_err_sticky and o_lane_err are unaffected.
// TESTING
//  1 Reset, then lanes {15,-16,0,-1,7}, SHIFT=0, i_ready=1 -> 1 cycle later o_valid=1,
//    lanes {15,-16,0,-1,7} sign-extended to 25b (-1 = 25'h1FFFFFF), o_lane_err=0.
//  2 SHIFT=4, lane 0 = -3 (8'hFD) -> o_acc_data lane0 = 25'h1FFFFD0; lane 5 in -> 25'h0000050.
//  3 Lanes {8'h20,8'h80,8'h10,8'hEF,8'hF0} -> outputs {15,-16,15,-16,-16}, o_lane_err=5'b11111 minus
//    lane4 (5'b01111); o_err_sticky=1; o_err_cnt=1 with macro, 0 without.
//  4 Backpressure: stream beats A,B,C with i_ready=0 -> A in OUT, B in SKD, o_ready=0, C held upstream.
//    Raise i_ready -> A,B,C delivered in order; o_ready=1 after B moves to OUT.
//  5 Full-rate stream of 100 beats with random i_ready -> output sequence equals input sequence;
//    o_valid & ~i_ready never changes data.
//  6 i_err_clr with an errored accept in the same cycle -> sticky=1, cnt=1.
//    Preload cnt=16'hFFFF plus one more errored beat -> stays FFFF.
//    Assert rst_n mid-stream with OUT/SKD full -> all outputs reset next edge, o_ready=1.

Source files
------------

// File: rtl/unbound_16.sv
// unbound_16: re-expands COLS packed signed BO_BW lanes (legal range [-16,15])
// into signed AB_BW lanes, clamping and flagging out-of-range inputs.
// Valid/ready on both sides with an output register plus a one-entry skid
// buffer, so a beat per cycle is sustained under continuous flow.
// Optional feature: define UNBOUND_ERR_CNT_EN to build the 16-bit saturating
// errored-beat counter; otherwise o_err_cnt is tied to zero.
module unbound_16 #(
  parameter int COLS  = 5,
  parameter int BO_BW = 8,
  parameter int AB_BW = 25,
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [BO_BW*COLS-1:0]   i_bound_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [AB_BW*COLS-1:0]   o_acc_data,
  output logic [COLS-1:0]         o_lane_err,
  input  logic                    i_err_clr,
  output logic                    o_err_sticky,
  output logic [15:0]             o_err_cnt
);

  // Configurations that could overflow the shifted lane, or cannot hold the
  // [-16,15] legal range, are rejected at elaboration.
  if (BO_BW + SHIFT > AB_BW) begin : g_bad_width
    $error("unbound_16: BO_BW + SHIFT must not exceed AB_BW");
  end
  if (BO_BW < 5) begin : g_bad_bo_bw
    $error("unbound_16: BO_BW must be at least 5");
  end

  localparam logic signed [BO_BW-1:0] LANE_MIN = BO_BW'(-16);
  localparam logic signed [BO_BW-1:0] LANE_MAX = BO_BW'(15);

  typedef struct packed {
    logic [AB_BW*COLS-1:0] data;
    logic [COLS-1:0]       err;
  } beat_t;

  logic [AB_BW*COLS-1:0] xf_data;
  logic [COLS-1:0]       xf_err;
  beat_t                 xf_beat;

  beat_t out_q, out_d;
  beat_t skd_q, skd_d;
  logic  out_valid_q, out_valid_d;
  logic  skd_valid_q, skd_valid_d;
  logic  sticky_q, sticky_d;

  logic accept;
  logic handoff;
  logic err_accept;

  // Per-lane clamp, sign extension and fixed-point rescale.
  for (genvar g = 0; g < COLS; g++) begin : g_lane
    logic signed [BO_BW-1:0] lane_x;
    logic signed [BO_BW-1:0] lane_c;
    logic signed [AB_BW-1:0] lane_ext;
    logic                    lane_err;

    assign lane_x = i_bound_data[(g+1)*BO_BW-1 -: BO_BW];

    // Saturate to [-16,15] and flag any lane that needed it.
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
      lane_c   = lane_x;
      lane_err = 1'b0;
      if (lane_x < LANE_MIN) begin
        lane_c   = LANE_MIN;
        lane_err = 1'b1;
      end else if (lane_x > LANE_MAX) begin
        lane_c   = LANE_MAX;
        lane_err = 1'b1;
      end
    end

    // Size cast of a signed operand sign-extends; the shift zero-fills.
    assign lane_ext = AB_BW'(lane_c);
    assign xf_data[(g+1)*AB_BW-1 -: AB_BW] = lane_ext <<< SHIFT;
    assign xf_err[g] = lane_err;
  end

  assign xf_beat.data = xf_data;
  assign xf_beat.err  = xf_err;

  assign o_ready    = ~skd_valid_q;
  assign accept     = i_valid & o_ready;
  assign handoff    = out_valid_q & i_ready;
  assign err_accept = accept & (|xf_err);

  // Output/skid steering: skid drains first, else a new beat fills OUT when
  // it is free (or freeing this cycle), else it parks in the skid entry.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    skd_d       = skd_q;
    skd_valid_d = skd_valid_q;
    if (handoff && skd_valid_q) begin
      out_d       = skd_q;
      skd_valid_d = 1'b0;
    end else if (accept && (!out_valid_q || handoff)) begin
      out_d       = xf_beat;
      out_valid_d = 1'b1;
    end else if (accept) begin
      skd_d       = xf_beat;
      skd_valid_d = 1'b1;
    end else if (handoff) begin
      out_valid_d = 1'b0;
    end
  end

  // Sticky error flag: clear first, then an errored accept sets it.
  always_comb begin
    sticky_d = i_err_clr ? 1'b0 : sticky_q;
    if (err_accept) begin
      sticky_d = 1'b1;
    end
  end

  // Pipeline and sticky state registers.
  // NOTE: the data registers are reset too, because o_acc_data must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      skd_q       <= '0;
      skd_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      skd_q       <= skd_d;
      skd_valid_q <= skd_valid_d;
      sticky_q    <= sticky_d;
    end
  end

`ifdef UNBOUND_ERR_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating count of errored accepts; clear takes effect before counting.
  always_comb begin
    cnt_d = i_err_clr ? 16'h0000 : cnt_q;
    if (err_accept && (cnt_d != 16'hFFFF)) begin
      cnt_d = cnt_d + 16'h0001;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_err_cnt = cnt_q;
`else
  assign o_err_cnt = 16'h0000;
`endif

  assign o_valid      = out_valid_q;
  assign o_acc_data   = out_q.data;
  assign o_lane_err   = out_q.err;
  assign o_err_sticky = sticky_q;

endmodule

// File: tb/tb_unbound_16.sv
// tb_unbound_16: directed steps for unbound_16 with a scoreboard of expected
// beats pushed at upstream accept and popped at downstream handoff.
module tb_unbound_16;

  localparam int COLS  = 5;
  localparam int BO_BW = 8;
  localparam int AB_BW = 25;
  localparam int DW    = AB_BW * COLS;
  localparam int IW    = BO_BW * COLS;

`ifdef UNBOUND_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [COLS-1:0] err;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_valid;
  logic            o_ready;
  logic [IW-1:0]   i_bound_data;
  logic            o_valid;
  logic            i_ready;
  logic [DW-1:0]   o_acc_data;
  logic [COLS-1:0] o_lane_err;
  logic            i_err_clr;
  logic            o_err_sticky;
  logic [15:0]     o_err_cnt;

  // Second instance with a rescale shift, always ready downstream.
  logic            s4_valid;
  logic            s4_o_ready;
  logic [IW-1:0]   s4_data;
  logic            s4_o_valid;
  logic            s4_i_ready;
  logic [DW-1:0]   s4_acc;
  logic [COLS-1:0] s4_err;
  logic            s4_sticky;
  logic [15:0]     s4_cnt;

  int errors = 0;
  int checks = 0;
  beat_t sb[$];
  bit mon_en = 1'b0;

  unbound_16 #(.COLS(COLS), .BO_BW(BO_BW), .AB_BW(AB_BW), .SHIFT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_bound_data(i_bound_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_acc_data(o_acc_data), .o_lane_err(o_lane_err), .i_err_clr(i_err_clr),
    .o_err_sticky(o_err_sticky), .o_err_cnt(o_err_cnt)
  );

  unbound_16 #(.COLS(COLS), .BO_BW(BO_BW), .AB_BW(AB_BW), .SHIFT(4)) u_dut_s4 (
    .clk(clk), .rst_n(rst_n), .i_valid(s4_valid), .o_ready(s4_o_ready),
    .i_bound_data(s4_data), .o_valid(s4_o_valid), .i_ready(s4_i_ready),
    .o_acc_data(s4_acc), .o_lane_err(s4_err), .i_err_clr(1'b0),
    .o_err_sticky(s4_sticky), .o_err_cnt(s4_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference transform written as integer arithmetic on each lane.
  function automatic beat_t model(input logic [IW-1:0] din, input int shift);
    beat_t b;
    b = '0;
    for (int i = 0; i < COLS; i++) begin
      int v;
      logic [31:0] t;
      v = $signed(din[i*BO_BW +: BO_BW]);
      if (v < -16) begin
        v = -16;
        b.err[i] = 1'b1;
      end else if (v > 15) begin
        v = 15;
        b.err[i] = 1'b1;
      end
      t = v * (1 << shift);
      b.data[i*AB_BW +: AB_BW] = t[AB_BW-1:0];
    end
    return b;
  endfunction

  function automatic logic [IW-1:0] pack(input int l0, input int l1, input int l2,
                                         input int l3, input int l4);
    logic [IW-1:0] d;
    logic [31:0] v [COLS];
    v[0] = l0; v[1] = l1; v[2] = l2; v[3] = l3; v[4] = l4;
    for (int i = 0; i < COLS; i++) d[i*BO_BW +: BO_BW] = v[i][BO_BW-1:0];
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampling on the falling edge while inputs are stable.
  logic            prev_stall = 1'b0;
  logic [DW-1:0]   prev_data;
  logic [COLS-1:0] prev_err;
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (prev_stall) begin
        check("hold_valid", o_valid, 1'b1);
        check("hold_data", o_acc_data, prev_data);
        check("hold_err", o_lane_err, prev_err);
      end
      if (o_valid && i_ready) begin
        check("sb_nonempty", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          beat_t e;
          e = sb.pop_front();
          check("sb_data", o_acc_data, e.data);
          check("sb_err", o_lane_err, e.err);
        end
      end
      if (i_valid && o_ready) sb.push_back(model(i_bound_data, 0));
      prev_stall = o_valid && !i_ready;
      prev_data  = o_acc_data;
      prev_err   = o_lane_err;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    beat_t ea;
    logic [IW-1:0] da, db, dc, derr;
    int n, cyc;
    bit acc;

    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_bound_data = '0; i_err_clr = 1'b0;
    s4_valid = 1'b0; s4_data = '0; s4_i_ready = 1'b1;
    tick(); tick();
    check("rst_o_valid", o_valid, 1'b0);
    check("rst_o_ready", o_ready, 1'b1);
    check("rst_data", o_acc_data, '0);
    check("rst_lane_err", o_lane_err, '0);
    check("rst_sticky", o_err_sticky, 1'b0);
    check("rst_cnt", o_err_cnt, 16'h0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // Step 1: in-range lanes, single-cycle latency, then output goes idle.
    i_ready = 1'b1; i_valid = 1'b1;
    i_bound_data = pack(15, -16, 0, -1, 7);
    tick();
    i_valid = 1'b0;
    check("t1_valid", o_valid, 1'b1);
    check("t1_lane0", o_acc_data[0*AB_BW +: AB_BW], 25'h000000F);
    check("t1_lane1", o_acc_data[1*AB_BW +: AB_BW], 25'h1FFFFF0);
    check("t1_lane3", o_acc_data[3*AB_BW +: AB_BW], 25'h1FFFFFF);
    check("t1_lane_err", o_lane_err, 5'b00000);
    tick();
    check("t1_idle_valid", o_valid, 1'b0);
    check("t1_idle_hold", o_acc_data[3*AB_BW +: AB_BW], 25'h1FFFFFF);
    check("t1_sticky", o_err_sticky, 1'b0);

    // Step 2: rescale by 4 on the second instance.
    s4_valid = 1'b1;
    s4_data = pack(-3, 5, 0, 15, -16);
    tick();
    s4_valid = 1'b0;
    check("t2_valid", s4_o_valid, 1'b1);
    check("t2_lane0", s4_acc[0*AB_BW +: AB_BW], 25'h1FFFFD0);
    check("t2_lane1", s4_acc[1*AB_BW +: AB_BW], 25'h0000050);
    check("t2_lane4", s4_acc[4*AB_BW +: AB_BW], 25'h1FFFF00);
    check("t2_err", s4_err, 5'b00000);

    // Step 3: out-of-range lanes clamp and flag; sticky one cycle later.
    i_valid = 1'b1;
    i_bound_data = pack(8'h20, 8'h80, 8'h10, 8'hEF, 8'hF0);
    tick();
    i_valid = 1'b0;
    check("t3_lane0", o_acc_data[0*AB_BW +: AB_BW], 25'h000000F);
    check("t3_lane1", o_acc_data[1*AB_BW +: AB_BW], 25'h1FFFFF0);
    check("t3_lane3", o_acc_data[3*AB_BW +: AB_BW], 25'h1FFFFF0);
    check("t3_lane_err", o_lane_err, 5'b01111);
    check("t3_sticky", o_err_sticky, 1'b1);
    check("t3_cnt", o_err_cnt, CNT_EN ? 16'h1 : 16'h0);
    tick();

    // Step 4: backpressure fills OUT and SKD, then drains in order.
    i_ready = 1'b0;
    da = pack(1, 2, 3, 4, 5);
    db = pack(-6, -7, -8, -9, -10);
    dc = pack(11, 12, 13, 14, 15);
    i_valid = 1'b1; i_bound_data = da;
    tick();
    check("t4_a_ready", o_ready, 1'b1);
    i_bound_data = db;
    tick();
    check("t4_b_ready_low", o_ready, 1'b0);
    i_bound_data = dc;
    tick();
    ea = model(da, 0);
    check("t4_c_held_ready", o_ready, 1'b0);
    check("t4_out_is_a", o_acc_data, ea.data);
    i_ready = 1'b1;
    tick();
    check("t4_ready_rise", o_ready, 1'b1);
    tick();
    i_valid = 1'b0;
    tick(); tick();
    check("t4_drained", sb.size(), 0);

    // Step 5: 100 random beats under random downstream stalls.
    n = 0; cyc = 0;
    i_bound_data = IW'({$urandom, $urandom});
    while (n < 100 && cyc < 2000) begin
      i_valid = 1'b1;
      i_ready = 1'($urandom_range(0, 1));
      acc = o_ready;
      tick();
      cyc++;
      if (acc) begin
        n++;
        i_bound_data = IW'({$urandom, $urandom});
      end
    end
    check("t5_beats_sent", n, 100);
    i_valid = 1'b0; i_ready = 1'b1;
    cyc = 0;
    while (sb.size() != 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    tick();
    check("t5_drained", sb.size(), 0);
    check("t5_idle", o_valid, 1'b0);

    // Step 6a: clear coinciding with an errored accept -> clear, then count.
    derr = pack(8'h7F, 0, 0, 0, 0);
    i_err_clr = 1'b1; i_valid = 1'b1; i_bound_data = derr;
    tick();
    i_err_clr = 1'b0; i_valid = 1'b0;
    check("t6_clr_acc_sticky", o_err_sticky, 1'b1);
    check("t6_clr_acc_cnt", o_err_cnt, CNT_EN ? 16'h1 : 16'h0);
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    check("t6_clr_sticky", o_err_sticky, 1'b0);
    check("t6_clr_cnt", o_err_cnt, 16'h0);

`ifdef UNBOUND_ERR_CNT_EN
    // Step 6b: counter saturates at FFFF.
    i_valid = 1'b1; i_bound_data = derr;
    repeat (65535) tick();
    check("t6_cnt_full", o_err_cnt, 16'hFFFF);
    tick();
    i_valid = 1'b0;
    check("t6_cnt_sat", o_err_cnt, 16'hFFFF);
    tick(); tick();
`endif

    // Step 6c: asynchronous reset with OUT and SKD both full.
    i_ready = 1'b0; i_valid = 1'b1; i_bound_data = da;
    tick();
    i_bound_data = db;
    tick();
    i_valid = 1'b0;
    check("t6_full_ready", o_ready, 1'b0);
    check("t6_full_valid", o_valid, 1'b1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", o_valid, 1'b0);
    check("t6_rst_ready", o_ready, 1'b1);
    check("t6_rst_data", o_acc_data, '0);
    check("t6_rst_err", o_lane_err, '0);
    check("t6_rst_sticky", o_err_sticky, 1'b0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    mon_en = 1'b1;
    i_ready = 1'b1;
    tick();
    check("t6_no_partial", o_valid, 1'b0);
    i_valid = 1'b1; i_bound_data = dc;
    tick();
    i_valid = 1'b0;
    check("t6_restart_valid", o_valid, 1'b1);
    tick(); tick();
    check("t6_final_drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
